fp32_dot_accumulator: RTL and testbench

FP32_DOT_ACCUMULATOR -- requirements
Module: fp32_dot_accumulator

---
 rtl/fp32_dot_accumulator.sv | 99 +++++++++
 tb/tb_fp32_dot_accumulator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_dot_accumulator.sv
// Sums LEN FP32 product terms through an external combinational adder, one term per cycle.
// Latency 1 cycle after the last term; in_ready drops while a result waits for out_ready or flush is high.
module fp32_dot_accumulator #(
  parameter int LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        flush,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_sum,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic {
    ACC,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   out_data_q, out_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          accept;

  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign in_ready  = (state_q == ACC) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == ACC) && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= 32'h0000_0000;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    // flush wins over any concurrent acceptance or output handshake; out_data is left as is
    if (flush) begin
      state_d     = ACC;
      acc_d       = 32'h0000_0000;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept) begin
            if (cnt_q == LAST) begin
              out_data_d  = add_sum;
              out_valid_d = 1'b1;
              acc_d       = 32'h0000_0000;
              cnt_d       = '0;
              state_d     = DONE;
            end else begin
              acc_d = add_sum;
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACC;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_dot_accumulator.sv
// Drives LEN=4, LEN=2 and LEN=1 instances from one shared stream; each has an exact bench-side adder
// and is checked against a per-instance model that sums accepted terms as fixed-point integers.
module tb_fp32_dot_accumulator;

  localparam logic [31:0] ONE  = 32'h3f80_0000;
  localparam logic [31:0] TWO  = 32'h4000_0000;
  localparam logic [31:0] FOUR = 32'h4080_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        flush;
  logic        out_ready;

  logic [2:0]  in_ready_w, out_valid_w, busy_w;
  logic [31:0] add_a_w [3];
  logic [31:0] add_b_w [3];
  logic [31:0] add_sum_w [3];
  logic [31:0] out_data_w [3];

  int          checks = 0;
  int          errors = 0;

  int          m_sum  [3];
  int          m_n    [3];
  bit          m_pend [3];
  logic [31:0] m_held [3];

  always #5 clk = ~clk;

  // Values are multiples of 1/16, so fixed-point with 4 fraction bits is exact.
  function automatic int fp_to_fix(input logic [31:0] f);
    int e;
    int mag;
    if (f[30:0] == 31'd0) return 0;
    e   = int'(f[30:23]) - 146;
    mag = int'({8'd0, 1'b1, f[22:0]});
    if (e >= 0) mag = mag <<< e;
    else        mag = mag >>> (-e);
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] fix_to_fp(input int v);
    logic [31:0] a;
    logic [31:0] m;
    int          p;
    if (v == 0) return 32'd0;
    a = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 31; i++) if (a[i]) p = i;
    m = a << (23 - p);
    return {(v < 0), 8'(p + 123), m[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return fix_to_fp(fp_to_fix(a) + fp_to_fix(b));
  endfunction

  function automatic int len_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic logic [31:0] rnd_term();
    return fix_to_fp(int'($urandom_range(0, 2048)) - 1024);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fp32_dot_accumulator #(.LEN((g == 0) ? 4 : ((g == 1) ? 2 : 1))) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready_w[g]),
      .flush    (flush),
      .add_a    (add_a_w[g]),
      .add_b    (add_b_w[g]),
      .add_sum  (add_sum_w[g]),
      .out_valid(out_valid_w[g]),
      .out_data (out_data_w[g]),
      .out_ready(out_ready),
      .busy     (busy_w[g])
    );
    assign add_sum_w[g] = fp_add(add_a_w[g], add_b_w[g]);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sum[i]  = 0;
      m_n[i]    = 0;
      m_pend[i] = 1'b0;
      m_held[i] = 32'd0;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out_valid[%0d]", i), 32'(out_valid_w[i]), 32'(m_pend[i]));
      chk($sformatf("out_data[%0d]", i), out_data_w[i], m_held[i]);
      chk($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(!m_pend[i] && m_n[i] != 0));
      chk($sformatf("add_a[%0d]", i), add_a_w[i], fix_to_fp(m_sum[i]));
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, advance models, check registered outputs.
  task automatic step(input logic v, input logic [31:0] d, input logic fl, input logic ordy);
    in_valid  = v;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("in_ready[%0d]", i), 32'(in_ready_w[i]), 32'(!m_pend[i] && !fl));
      chk($sformatf("add_b[%0d]", i), add_b_w[i], d);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (fl) begin
        m_sum[i]  = 0;
        m_n[i]    = 0;
        m_pend[i] = 1'b0;
      end else if (m_pend[i]) begin
        if (ordy) m_pend[i] = 1'b0;
      end else if (v) begin
        m_sum[i] += fp_to_fix(d);
        m_n[i]++;
        if (m_n[i] == len_of(i)) begin
          m_held[i] = fix_to_fp(m_sum[i]);
          m_pend[i] = 1'b1;
          m_sum[i]  = 0;
          m_n[i]    = 0;
        end
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic hard_reset();
    flush = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    for (int i = 0; i < 3; i++) chk($sformatf("rst_in_ready[%0d]", i), 32'(in_ready_w[i]), 32'd1);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #2;
    check_outputs();
    for (int i = 0; i < 3; i++) chk($sformatf("rst_in_ready[%0d]", i), 32'(in_ready_w[i]), 32'd1);
    #5;
    rst_n = 1'b1;

    // four ones back to back, result drains immediately
    for (int k = 0; k < 4; k++) step(1'b1, ONE, 1'b0, 1'b1);
    chk("s33_valid", 32'(out_valid_w[0]), 32'd1);
    chk("s33_data", out_data_w[0], FOUR);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("s33_valid_drop", 32'(out_valid_w[0]), 32'd0);

    // 3.0 + -3.75 on the LEN=2 instance
    step(1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b1, 32'h4040_0000, 1'b0, 1'b1);
    step(1'b1, 32'hc070_0000, 1'b0, 1'b1);
    chk("s34_data", out_data_w[1], 32'hbf40_0000);
    step(1'b0, 32'd0, 1'b1, 1'b1);

    // result stalled by out_ready=0 while upstream keeps offering 2.0
    for (int k = 0; k < 4; k++) step(1'b1, ONE, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, TWO, 1'b0, 1'b0);
      chk("s35_hold", out_data_w[0], FOUR);
    end
    step(1'b1, TWO, 1'b0, 1'b1);
    step(1'b1, TWO, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, ONE, 1'b0, 1'b1);
    chk("s35_data", out_data_w[0], 32'h40a0_0000);
    step(1'b0, 32'd0, 1'b1, 1'b1);

    // partial sum discarded by flush, even with a term offered on the flush cycle
    step(1'b1, TWO, 1'b0, 1'b1);
    step(1'b1, TWO, 1'b0, 1'b1);
    step(1'b1, TWO, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, ONE, 1'b0, 1'b1);
    chk("s36_data", out_data_w[0], FOUR);
    step(1'b0, 32'd0, 1'b0, 1'b1);

    // reset after three of four terms
    for (int k = 0; k < 3; k++) step(1'b1, ONE, 1'b0, 1'b1);
    hard_reset();
    for (int k = 0; k < 4; k++) step(1'b1, ONE, 1'b0, 1'b1);
    chk("s37_data", out_data_w[0], FOUR);
    step(1'b0, 32'd0, 1'b0, 1'b1);

    // in_valid toggling with garbage data on idle cycles
    for (int k = 0; k < 7; k++) step((k % 2) == 0, (k % 2) == 0 ? ONE : 32'h7f80_0000, 1'b0, 1'b1);
    chk("s38_valid", 32'(out_valid_w[0]), 32'd1);
    chk("s38_data", out_data_w[0], FOUR);
    step(1'b0, 32'd0, 1'b0, 1'b1);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) hard_reset();
      step($urandom_range(0, 3) != 0, rnd_term(), $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
